// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot-stage program loader. Receives an image over an 8N1 UART line and writes it
//   into instruction memory one 32-bit word at a time. The core is held in reset
//   while a load is in progress and released once the image is complete.
//
//   Image format on the wire: 0xA5 header, one count byte N (words), then 4*N data
//   bytes, least-significant byte of each word first. N is clamped to the memory depth.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   rx         in   UART serial input (idle high, LSB first)
//   load_req   in   one-cycle pulse that arms the loader (honoured in IDLE/DONE/ERR)
//   imem_we    out  instruction-memory write strobe, one cycle per word
//   imem_addr  out  word address of the current write
//   imem_wdata out  assembled write word
//   cpu_rst    out  hold-in-reset to the core (high in HDR/CNT/DATA/ERR)
//   busy       out  load in progress (HDR/CNT/DATA)
//   done       out  image complete
//   frame_err  out  a stop bit was low during the load
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TOT_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam int DEPTH = 2 ** ADDR_W;

    // ---------------- RX front end ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_reg;
    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [2:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             ferr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_reg <= RX_IDLE;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte      <= '0;
            byte_valid   <= 1'b0;
            ferr         <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            byte_valid  <= 1'b0;
            ferr        <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    // A genuine falling edge is required, so a line still held low
                    // after a bad stop bit does not immediately start a new frame.
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                        rx_cnt_reg <= '0;
                        rx_bit_reg <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 1'b1;
                        if (rx_bit_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift_reg;
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Loader FSM ----------------
    typedef enum logic [2:0] {L_IDLE, L_HDR, L_CNT, L_DATA, L_DONE, L_ERR} ld_state_t;

    ld_state_t        ld_state_reg;
    logic [TOT_W-1:0] word_total_reg;
    logic [TOT_W-1:0] word_cnt_reg;
    logic [1:0]       byte_idx_reg;
    logic [TOT_W-1:0] count_clamped;

    assign count_clamped = (int'(rx_byte) > DEPTH) ? TOT_W'(DEPTH) : TOT_W'(rx_byte);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_state_reg   <= L_IDLE;
            word_total_reg <= '0;
            word_cnt_reg   <= '0;
            byte_idx_reg   <= '0;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= '0;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            case (ld_state_reg)
                L_IDLE, L_DONE, L_ERR: begin
                    if (ld_state_reg == L_IDLE)
                        cpu_rst <= 1'b0;
                    // Incoming bytes are ignored here, so a request always wins.
                    if (load_req) begin
                        ld_state_reg <= L_HDR;
                        imem_addr    <= '0;
                        byte_idx_reg <= '0;
                        word_cnt_reg <= '0;
                        done         <= 1'b0;
                        frame_err    <= 1'b0;
                        busy         <= 1'b1;
                        cpu_rst      <= 1'b1;
                    end
                end
                L_HDR, L_CNT: begin
                    if (ferr) begin
                        ld_state_reg <= L_ERR;
                        frame_err    <= 1'b1;
                        busy         <= 1'b0;
                    end else if (byte_valid) begin
                        if (ld_state_reg == L_HDR) begin
                            if (rx_byte == 8'hA5)
                                ld_state_reg <= L_CNT;
                        end else if (rx_byte == 8'h00) begin
                            ld_state_reg <= L_DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            cpu_rst      <= 1'b0;
                        end else begin
                            word_total_reg <= count_clamped;
                            ld_state_reg   <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (imem_we) begin
                        // Write cycle just finished: advance address and word count.
                        imem_we      <= 1'b0;
                        imem_addr    <= imem_addr + 1'b1;
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                        if (word_cnt_reg + TOT_W'(1) == word_total_reg) begin
                            ld_state_reg <= L_DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            cpu_rst      <= 1'b0;
                        end
                    end else if (ferr) begin
                        ld_state_reg <= L_ERR;
                        frame_err    <= 1'b1;
                        busy         <= 1'b0;
                    end else if (byte_valid) begin
                        imem_wdata[byte_idx_reg*8 +: 8] <= rx_byte;
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        if (byte_idx_reg == 2'd3)
                            imem_we <= 1'b1;
                    end
                end
                default: ld_state_reg <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader (CLKS_PER_BIT=16, ADDR_W=6).
// A reference model parses each transmitted byte stream (header search, count clamp,
// little-endian packing) and pushes the expected memory writes into a queue; a monitor
// pops that queue whenever the DUT strobes imem_we.
module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          load_req = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst, busy, done, frame_err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .load_req(load_req),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  bv_cnt = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) if (dut.byte_valid) bv_cnt++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (imem_we) begin
            wr_t e;
            n_cmp++;
            if (prev_we) begin
                n_bad++;
                $display("FAIL we_back_to_back: imem_we high two cycles in a row at addr %0d", imem_addr);
            end
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %08h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.a || imem_wdata !== e.d) begin
                    n_bad++;
                    $display("FAIL write: got addr %0d data %08h, expected addr %0d data %08h",
                             imem_addr, imem_wdata, e.a, e.d);
                end else begin
                    $display("write ok: addr %0d data %08h", imem_addr, imem_wdata);
                end
            end
        end
        prev_we <= imem_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check ok: %s = %0h", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop;
        cycles(CPB);
        rx = 1'b1;
        cycles(2 * CPB);
    endtask

    task automatic send_seq(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
    endtask

    task automatic pulse_load();
        @(posedge clk); #1;
        load_req = 1'b1;
        cycles(1);
        load_req = 1'b0;
    endtask

    // Reference model: from the bytes the loader actually receives, derive the writes.
    task automatic model_load(input logic [7:0] bs[$], output int nw, output bit complete);
        int h = -1;
        int n;
        nw = 0;
        complete = 1'b0;
        for (int i = 0; i < bs.size(); i++)
            if (h < 0 && bs[i] == 8'hA5) h = i;
        if (h < 0 || h + 1 >= bs.size()) return;
        n = bs[h + 1];
        if (n > 2 ** AW) n = 2 ** AW;
        for (int w = 0; w < n; w++) begin
            int p = h + 2 + 4 * w;
            wr_t e;
            if (p + 3 >= bs.size()) break;
            e.a = AW'(w % (2 ** AW));
            e.d = {bs[p + 3], bs[p + 2], bs[p + 1], bs[p]};
            exp_q.push_back(e);
            nw++;
        end
        complete = (nw == n);
    endtask

    task automatic check_done(input string tag, input int nw);
        cycles(4);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 0);
        check({tag, "_addr"}, imem_addr, AW'(nw % (2 ** AW)));
    endtask

    initial begin
        logic [7:0] bs[$];
        int  nw, b0;
        bit  cmpl;

        // Reset state
        rst = 1'b0;
        cycles(5);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        rst = 1'b1;
        cycles(3);
        check("idle_cpu_rst", cpu_rst, 0);

        // 1: two words
        bs = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pulse_load();
        check("t1_busy", busy, 1);
        check("t1_cpu_rst", cpu_rst, 1);
        model_load(bs, nw, cmpl);
        send_seq(bs);
        check_done("t1", nw);

        // 2: junk byte before header
        bs = '{8'h00, 8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
        pulse_load();
        check("t2_done_cleared", done, 0);
        model_load(bs, nw, cmpl);
        send_seq(bs);
        check_done("t2", nw);

        // 3: bad stop bit on third byte
        pulse_load();
        bs = '{8'hA5, 8'h03};
        model_load(bs, nw, cmpl);
        send_seq(bs);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        cycles(4);
        check("t3_ferr", frame_err, 1);
        check("t3_cpu_rst", cpu_rst, 1);
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);
        check("t3_queue_left", exp_q.size(), 0);

        // 4: glitch and unarmed bytes while IDLE
        @(posedge clk); #1; rst = 1'b0;
        cycles(1); rst = 1'b1;
        cycles(3);
        b0 = bv_cnt;
        rx = 1'b0; cycles(4); rx = 1'b1;
        cycles(3 * CPB);
        check("t4_glitch_bytes", bv_cnt - b0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        check("t4_real_bytes", bv_cnt - b0, 2);
        check("t4_busy", busy, 0);
        check("t4_cpu_rst", cpu_rst, 0);
        check("t4_ferr", frame_err, 0);

        // 5: reset in the middle of the second word
        bs = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_load();
        model_load(bs, nw, cmpl);
        send_seq(bs);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("t5_we", imem_we, 0);
        check("t5_addr", imem_addr, 0);
        check("t5_wdata", imem_wdata, 0);
        check("t5_busy", busy, 0);
        check("t5_cpu_rst_in_rst", cpu_rst, 1);
        cycles(3);
        check("t5_cpu_rst_idle", cpu_rst, 0);
        check("t5_done", done, 0);
        check("t5_queue_left", exp_q.size(), 0);

        // Randomised loads with random junk ahead of the header
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 6);
            int j = $urandom_range(0, 2);
            bs = {};
            for (int k = 0; k < j; k++) begin
                logic [7:0] v = 8'($urandom_range(0, 255));
                if (v == 8'hA5) v = 8'h5A;
                bs.push_back(v);
            end
            bs.push_back(8'hA5);
            bs.push_back(8'(n));
            for (int k = 0; k < 4 * n; k++) bs.push_back(8'($urandom_range(0, 255)));
            pulse_load();
            model_load(bs, nw, cmpl);
            send_seq(bs);
            check_done($sformatf("rand%0d", r), nw);
        end

        // 6: oversized count clamps to the memory depth
        bs = '{8'hA5, 8'hFF};
        for (int k = 0; k < 256; k++) bs.push_back(8'($urandom_range(0, 255)));
        pulse_load();
        model_load(bs, nw, cmpl);
        send_seq(bs);
        check_done("t6", nw);
        check("t6_words", nw, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
